// File: rtl/fft_input_buffer.sv
// Collects an N-sample complex frame, splits it into even/odd halves sign-extended
// to W+N/2 bits, and holds it on xe/xo until the butterfly stage accepts it.
module fft_input_buffer #(
  parameter int N = 16,
  parameter int W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sof,
  input  logic signed [W-1:0]     in_re,
  input  logic signed [W-1:0]     in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [W+N/2-1:0] xe [N/2][2],
  output logic signed [W+N/2-1:0] xo [N/2][2],
  output logic                    frame_err
);

  localparam int OW = W + N / 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] wr_cnt, wr_cnt_nxt;
  logic [CW-1:0] wr_idx;
  logic          wr_en;
  logic          err_nxt;

  function automatic logic signed [OW-1:0] sext(input logic signed [W-1:0] v);
    return {{(OW - W){v[W-1]}}, v};
  endfunction

  assign in_ready  = (state == FILL);
  assign out_valid = (state == HOLD);

  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    wr_idx     = wr_cnt;
    wr_en      = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      FILL: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (in_sof) begin
            // A start marker always restarts the frame at index 0, even at the last slot.
            wr_idx     = '0;
            wr_cnt_nxt = CW'(1);
            err_nxt    = (wr_cnt != '0);
          end else if (wr_cnt == LAST) begin
            wr_cnt_nxt = '0;
            state_nxt  = HOLD;
          end else begin
            wr_cnt_nxt = wr_cnt + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      wr_cnt    <= '0;
      frame_err <= 1'b0;
      for (int k = 0; k < N / 2; k++) begin
        for (int c = 0; c < 2; c++) begin
          xe[k][c] <= '0;
          xo[k][c] <= '0;
        end
      end
    end else begin
      state     <= state_nxt;
      wr_cnt    <= wr_cnt_nxt;
      frame_err <= err_nxt;
      // Even indices land in xe, odd in xo; the upper index bits select the slot.
      if (wr_en) begin
        if (!wr_idx[0]) begin
          xe[wr_idx[CW-1:1]][0] <= sext(in_re);
          xe[wr_idx[CW-1:1]][1] <= sext(in_im);
        end else begin
          xo[wr_idx[CW-1:1]][0] <= sext(in_re);
          xo[wr_idx[CW-1:1]][1] <= sext(in_im);
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_input_buffer.sv
// Directed and table-driven bench for fft_input_buffer (N=16, W=16).
module tb_fft_input_buffer;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, in_sof;
  logic signed [15:0] in_re, in_im;
  logic               out_valid, out_ready;
  logic signed [23:0] xe [8][2];
  logic signed [23:0] xo [8][2];
  logic               frame_err;

  int tests = 0;
  int fails = 0;
  logic [23:0] exp_re [16];
  logic [23:0] exp_im [16];

  typedef struct {
    logic        vld;
    logic        sof;
    logic [15:0] re;
    logic [15:0] im;
    logic        ordy;
    logic        e_ird;
    logic        e_ovld;
    logic        e_err;
  } vec_t;
  vec_t tbl[$];

  fft_input_buffer #(.N(16), .W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .xe(xe), .xo(xo), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] r, input logic [15:0] i,
                       input logic o);
    in_valid  = v;
    in_sof    = s;
    in_re     = r;
    in_im     = i;
    out_ready = o;
  endtask

  task automatic put(input int idx, input logic [15:0] r, input logic [15:0] i);
    exp_re[idx] = 24'(int'($signed(r)));
    exp_im[idx] = 24'(int'($signed(i)));
  endtask

  task automatic check_frame(input string nm);
    for (int k = 0; k < 8; k++) begin
      chk({nm, "_xe_re"}, xe[k][0], exp_re[2*k]);
      chk({nm, "_xe_im"}, xe[k][1], exp_im[2*k]);
      chk({nm, "_xo_re"}, xo[k][0], exp_re[2*k+1]);
      chk({nm, "_xo_im"}, xo[k][1], exp_im[2*k+1]);
    end
  endtask

  task automatic consume(input string nm);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
    step();
    chk({nm, "_cons_ovld"}, out_valid, 1'b0);
    chk({nm, "_cons_ird"}, in_ready, 1'b1);
    out_ready = 1'b0;
  endtask

  initial begin
    int m_cnt;
    int frames;
    int cyc;
    bit m_hold;
    bit checked;
    logic v, s, o;
    logic [15:0] r, i;

    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("rst_ird", in_ready, 1'b1);
    chk("rst_ovld", out_valid, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_xe", xe[0][0], 24'h0);
    chk("rst_xo", xo[7][1], 24'h0);

    // Ramp frame followed by 20 cycles of back-pressure with toggling input.
    for (int k = 0; k < 16; k++) begin
      tbl.push_back('{1'b1, (k == 0), 16'(k), 16'(-k), 1'b0, (k != 15), (k == 15), 1'b0});
      put(k, 16'(k), 16'(-k));
    end
    for (int j = 0; j < 20; j++)
      tbl.push_back('{(j % 2 == 0), (j % 4 == 0), 16'($urandom), 16'($urandom),
                      1'b0, 1'b0, 1'b1, 1'b0});
    foreach (tbl[n]) begin
      drive(tbl[n].vld, tbl[n].sof, tbl[n].re, tbl[n].im, tbl[n].ordy);
      step();
      chk($sformatf("vec%0d_ird", n), in_ready, tbl[n].e_ird);
      chk($sformatf("vec%0d_ovld", n), out_valid, tbl[n].e_ovld);
      chk($sformatf("vec%0d_err", n), frame_err, tbl[n].e_err);
    end
    check_frame("ramp");
    chk("ramp_xe1_im", xe[1][1], 24'hFFFFFE);
    chk("ramp_xo7_im", xo[7][1], 24'hFFFFF1);
    consume("ramp");

    // Resync after 5 samples.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, (k == 0), 16'(100 + k), 16'(200 + k), 1'b0);
      step();
    end
    chk("rs_err_pre", frame_err, 1'b0);
    drive(1'b1, 1'b1, 16'h7FFF, 16'h8000, 1'b0);
    put(0, 16'h7FFF, 16'h8000);
    step();
    chk("rs_err_pulse", frame_err, 1'b1);
    for (int k = 1; k < 16; k++) begin
      drive(1'b1, 1'b0, 16'(k * 3), 16'(-k * 5), 1'b0);
      put(k, 16'(k * 3), 16'(-k * 5));
      step();
      if (k == 1) chk("rs_err_clear", frame_err, 1'b0);
      if (k == 14) chk("rs_ovld_early", out_valid, 1'b0);
    end
    chk("rs_ovld", out_valid, 1'b1);
    chk("rs_xe0_re", xe[0][0], 24'h007FFF);
    chk("rs_xe0_im", xe[0][1], 24'hFF8000);
    check_frame("rs");
    consume("rs");

    // Start marker on the final index restarts the frame instead of completing it.
    for (int k = 0; k < 15; k++) begin
      drive(1'b1, (k == 0), 16'(k + 40), 16'(k + 60), 1'b0);
      step();
    end
    drive(1'b1, 1'b1, 16'h1234, 16'hFEDC, 1'b0);
    put(0, 16'h1234, 16'hFEDC);
    step();
    chk("last_err", frame_err, 1'b1);
    chk("last_ovld", out_valid, 1'b0);
    chk("last_ird", in_ready, 1'b1);
    for (int k = 1; k < 16; k++) begin
      drive(1'b1, 1'b0, 16'(k * 1000), 16'(-k * 999), 1'b0);
      put(k, 16'(k * 1000), 16'(-k * 999));
      step();
    end
    chk("last_hold", out_valid, 1'b1);
    check_frame("last");
    consume("last");

    // Random gaps on both handshakes over two frames.
    m_cnt = 0; frames = 0; cyc = 0; m_hold = 1'b0; checked = 1'b0;
    while (frames < 2 && cyc < 400) begin
      chk("gap_ird", in_ready, !m_hold);
      chk("gap_ovld", out_valid, m_hold);
      if (m_hold && !checked) begin
        check_frame("gap");
        checked = 1'b1;
      end
      v = 1'($urandom % 2);
      o = 1'($urandom % 2);
      r = 16'($urandom);
      i = 16'($urandom);
      s = (m_cnt == 0) && ($urandom % 2 == 1);
      drive(v, s, r, i, o);
      if (m_hold) begin
        if (o) begin
          m_hold = 1'b0;
          frames++;
        end
      end else if (v) begin
        put(m_cnt, r, i);
        if (m_cnt == 15) begin
          m_hold  = 1'b1;
          checked = 1'b0;
          m_cnt   = 0;
        end else begin
          m_cnt++;
        end
      end
      step();
      cyc++;
    end
    if (frames < 2) begin
      tests++;
      fails++;
      $display("FAIL gap_timeout: got %0d frames expected 2", frames);
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();

    // Extreme values, then an asynchronous reset while holding.
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, (k == 0), 16'h8000, 16'h7FFF, 1'b0);
      put(k, 16'h8000, 16'h7FFF);
      step();
    end
    chk("ext_ovld", out_valid, 1'b1);
    chk("ext_xe5_re", xe[5][0], 24'hFF8000);
    chk("ext_xo2_im", xo[2][1], 24'h007FFF);
    check_frame("ext");

    #2 rst = 1'b1;
    #1;
    chk("arst_ovld", out_valid, 1'b0);
    chk("arst_ird", in_ready, 1'b1);
    chk("arst_xe", xe[3][0], 24'h0);
    chk("arst_xo", xo[6][1], 24'h0);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    rst      = 1'b0;
    step();
    chk("post_rst_ovld", out_valid, 1'b0);
    chk("post_rst_ird", in_ready, 1'b1);
    chk("post_rst_err", frame_err, 1'b0);
    for (int k = 0; k < 16; k++) put(k, 16'h0, 16'h0);
    check_frame("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
